pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
Parametrised multi-channel PWM peripheral, the next generation of the fixed 2-channel PWM on the main bus. It adds configurable channel count and counter width, a shared clock prescaler, edge- or center-aligned mode per channel, output inversion, and glitch-free double-buffered PERIOD/DUTY updates. It sits behind the same req/gnt register-bus adapter used by bus hosts. A period-complete interrupt drives the system interrupt controller.

Parameters:
NumChannels, 4, number of independent PWM channels (1..8).
CntWidth, 16, width of the PERIOD, DUTY and counter fields (2..32).

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
req_i  input  1  register access request
gnt_o  output  1  grant; combinationally equal to req_i
addr_i  input  8  byte address; addr_i[1:0] ignored
we_i  input  1  write enable
wdata_i  input  32  write data
be_i  input  4  byte enables, applied per byte on writes
rvalid_o  output  1  response valid, one cycle after grant
rdata_o  output  32  read data, valid with rvalid_o; 0 for writes
err_o  output  1  error, valid with rvalid_o
cio_pwm_o  output  NumChannels  PWM outputs
cio_pwm_en_o  output  NumChannels  output enables
intr_period_o  output  1  OR of STATUS flags

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low. Reset clears all registers, shadows, counters, rvalid_o, err_o, rdata_o, cio_pwm_o, cio_pwm_en_o and intr_period_o to 0.
- Register map:
  - 0x00 CTRL: [0] GEN (global enable); [15:8] PRESCALE.
  - 0x04 STATUS: [NumChannels-1:0] sticky period-complete flags, write-1-to-clear.
  - Channel c at 0x10+0x10*c:
    - +0x0 CFG: [0] EN, [1] INV, [2] CENTER.
    - +0x4 PERIOD: [CntWidth-1:0].
    - +0x8 DUTY: [CntWidth-1:0].
    - +0xC is unmapped.
  - Unused bits read 0.
- Bus:
  - Writes update the register at the clock edge ending the grant cycle.
  - The response follows on the next cycle: rvalid_o=1, err_o=1 for an unmapped address, a channel index >= NumChannels, or a write to a read-only location.
  - An erroring access has no side effect.
  - Reads return the programmed register value, not the shadow.
- Prescaler:
  - 8-bit counter runs while GEN=1; a tick fires every PRESCALE+1 clocks.
  - PRESCALE=0 ticks every cycle.
  - GEN=0 holds the prescaler and all channel counters at 0.
- Channel active condition: GEN & EN. cio_pwm_en_o[c] equals this term, registered.
- Shadows:
  - On entering active (either bit rising), PERIOD and DUTY are loaded into shadows and the counter is set to 0.
  - Thereafter the shadows reload only at the period boundary, so there is never a partial period.
- Edge mode (CENTER=0):
  - Counter counts up 0..Ps on ticks, then wraps to 0. The boundary is the tick at cnt==Ps.
  - Raw output = cnt < Ds.
- Center mode (CENTER=1):
  - Counter counts up to Ps, then down to 0, then repeats. Period = 2*Ps ticks.
  - The boundary is the tick at which cnt reaches 0 while counting down.
  - Raw output = cnt < Ds.
- Duty limits: Ds=0 gives constant low; Ds>Ps gives constant high.
- Ps=0: the counter stays 0, raw output = (Ds!=0), and every tick is a boundary.
- Output: cio_pwm_o[c] = registered (raw XOR INV) while active. It is 0 when inactive, regardless of INV.
- STATUS[c] sets at each boundary. Set has priority over a simultaneous W1C.
- Changing CENTER while active restarts that channel's counter at 0 with a shadow reload.
- Output latency: raw compare to pin is one clock.

Test Plan:
- Reset with the bus idle -> all outputs 0, every register reads 0, STATUS=0.
- Edge mode: CTRL=0x0001, CH0 PERIOD=9, DUTY=3, CFG=1 -> cio_pwm_o[0] high 3 clocks, low 7, repeating every 10 clocks. STATUS[0] sets every 10 clocks and intr_period_o asserts.
- Mid-period write DUTY=7 -> the current period keeps a 3-high pattern. The next period is 7 high / 3 low with no glitch.
- Center mode, PERIOD=4, DUTY=2, PRESCALE=1 -> 16-clock period; output high while cnt<2, centered around the cnt=0 point. Set INV=1 -> complementary waveform.
- Limits: DUTY=0 -> constant 0. DUTY=PERIOD+1 -> constant 1. PERIOD=0, DUTY=1 -> constant 1 with STATUS set every tick.
- Bus errors: read 0x0C, access channel NumChannels, write 0x04 with 0 -> err_o=1 for the first two. W1C of 0 leaves STATUS unchanged. Asserting rst_ni low mid-waveform -> outputs 0 asynchronously.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM peripheral behind a req/gnt register bus.
//
// Each channel runs edge- or center-aligned. Outputs can be inverted.
// PERIOD and DUTY are double-buffered: a channel only picks up new values
// at the end of a full period, so the waveform never shows a partial period.
// All channels share one 8-bit clock prescaler.
//
// Ports:
//   clk_i, rst_ni        clock and asynchronous active-low reset
//   req_i / gnt_o        access request; the grant is combinationally equal to req_i
//   addr_i, we_i         byte address (addr_i[1:0] ignored) and write enable
//   wdata_i, be_i        write data and per-byte enables
//   rvalid_o             response valid, one cycle after the grant
//   rdata_o, err_o       read data (0 for writes) and the error flag
//   cio_pwm_o            PWM pins
//   cio_pwm_en_o         pin output enables (channel active, registered)
//   intr_period_o        OR of the sticky period-complete flags
module pwm_multi #(
    parameter int NumChannels = 4,
    parameter int CntWidth    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [7:0]             addr_i,
    input  logic                   we_i,
    input  logic [31:0]            wdata_i,
    input  logic [3:0]             be_i,
    output logic                   rvalid_o,
    output logic [31:0]            rdata_o,
    output logic                   err_o,
    output logic [NumChannels-1:0] cio_pwm_o,
    output logic [NumChannels-1:0] cio_pwm_en_o,
    output logic                   intr_period_o
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    // Programmed registers
    logic                   gen_q;
    logic [7:0]             prescale_q;
    logic [NumChannels-1:0] status_q;
    logic [NumChannels-1:0] en_q;
    logic [NumChannels-1:0] inv_q;
    logic [NumChannels-1:0] center_q;
    logic [CntWidth-1:0]    period_q [NumChannels];
    logic [CntWidth-1:0]    duty_q   [NumChannels];

    // Bus response
    logic        rvalid_q;
    logic        err_q;
    logic [31:0] rdata_q;

    // Prescaler
    logic [7:0] presc_cnt_q;
    logic       tick;

    // Channel engine
    logic [NumChannels-1:0] act_q;
    logic [NumChannels-1:0] center_seen_q;
    logic [NumChannels-1:0] pwm_q;
    logic [NumChannels-1:0] pwm_en_q;
    logic [CntWidth-1:0]    cnt_q [NumChannels];
    logic [CntWidth-1:0]    ps_q  [NumChannels];
    logic [CntWidth-1:0]    ds_q  [NumChannels];
    dir_e                   dir_q [NumChannels];

    logic [NumChannels-1:0] active;
    logic [NumChannels-1:0] restart;
    logic [NumChannels-1:0] running;
    logic [NumChannels-1:0] raw;
    logic [NumChannels-1:0] at_end;
    logic [NumChannels-1:0] boundary;
    logic [NumChannels-1:0] w1c;

    // Address decode
    logic [3:0]  region;
    logic [3:0]  ch_idx;
    logic [1:0]  offset;
    logic        is_chan;
    logic        ch_ok;
    logic        dec_err;
    logic        wr_en;
    logic [31:0] rd_mux;
    logic [31:0] wr_merged;

    // The low address bits select bytes within a word, which this block ignores.
    logic unused_addr;
    assign unused_addr = ^addr_i[1:0];

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Region 0 holds the global registers. Region n (n >= 1) is channel n-1.
    // rd_mux doubles as the "old value" for byte-enable merging on writes.
    always_comb begin
        region  = addr_i[7:4];
        offset  = addr_i[3:2];
        is_chan = (region != 4'd0);
        ch_idx  = region - 4'd1;
        ch_ok   = (int'(ch_idx) < NumChannels);
        if (is_chan) dec_err = !ch_ok || (offset == 2'd3);
        else         dec_err = offset[1];

        rd_mux = '0;
        if (!is_chan) begin
            case (offset)
                2'd0:    rd_mux = {16'h0, prescale_q, 7'h0, gen_q};
                2'd1:    rd_mux = 32'(status_q);
                default: rd_mux = '0;
            endcase
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                if (ch_idx == 4'(c)) begin
                    case (offset)
                        2'd0:    rd_mux = {29'h0, center_q[c], inv_q[c], en_q[c]};
                        2'd1:    rd_mux = 32'(period_q[c]);
                        2'd2:    rd_mux = 32'(duty_q[c]);
                        default: rd_mux = '0;
                    endcase
                end
            end
        end

        wr_merged = merge_be(rd_mux, wdata_i, be_i);
        wr_en     = req_i && we_i && !dec_err;

        w1c = '0;
        if (wr_en && !is_chan && (offset == 2'd1) && be_i[0]) begin
            w1c = wdata_i[NumChannels-1:0];
        end
    end

    assign gnt_o = req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= req_i;
            err_q    <= req_i && dec_err;
            rdata_q  <= (req_i && !we_i && !dec_err) ? rd_mux : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gen_q      <= 1'b0;
            prescale_q <= '0;
            en_q       <= '0;
            inv_q      <= '0;
            center_q   <= '0;
            for (int c = 0; c < NumChannels; c++) begin
                period_q[c] <= '0;
                duty_q[c]   <= '0;
            end
        end else if (wr_en) begin
            if (!is_chan) begin
                if (offset == 2'd0) begin
                    gen_q      <= wr_merged[0];
                    prescale_q <= wr_merged[15:8];
                end
            end else begin
                for (int c = 0; c < NumChannels; c++) begin
                    if (ch_idx == 4'(c)) begin
                        case (offset)
                            2'd0: begin
                                en_q[c]     <= wr_merged[0];
                                inv_q[c]    <= wr_merged[1];
                                center_q[c] <= wr_merged[2];
                            end
                            2'd1:    period_q[c] <= wr_merged[CntWidth-1:0];
                            2'd2:    duty_q[c]   <= wr_merged[CntWidth-1:0];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // A flag set by a boundary wins over a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) status_q <= '0;
        else         status_q <= (status_q & ~w1c) | boundary;
    end

    // The >= compare keeps the prescaler from running the full 8-bit range
    // when PRESCALE is lowered below the current count.
    assign tick = gen_q && (presc_cnt_q >= prescale_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             presc_cnt_q <= '0;
        else if (!gen_q || tick) presc_cnt_q <= '0;
        else                     presc_cnt_q <= presc_cnt_q + 8'd1;
    end

    // restart covers entry into the active state and a CENTER change while
    // active. Both reload the shadows and begin a fresh period from 0.
    // In center mode, the boundary is the down-count step from 1 to 0.
    always_comb begin
        for (int c = 0; c < NumChannels; c++) begin
            active[c]  = gen_q & en_q[c];
            restart[c] = active[c] & (~act_q[c] | (center_q[c] ^ center_seen_q[c]));
            running[c] = active[c] & ~restart[c];
            raw[c]     = (cnt_q[c] < ds_q[c]);
            if (ps_q[c] == '0)    at_end[c] = 1'b1;
            else if (!center_q[c]) at_end[c] = (cnt_q[c] == ps_q[c]);
            else                   at_end[c] = (dir_q[c] == DIR_DOWN) && (cnt_q[c] == CntOne);
            boundary[c] = running[c] & tick & at_end[c];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q         <= '0;
            center_seen_q <= '0;
            pwm_q         <= '0;
            pwm_en_q      <= '0;
            for (int c = 0; c < NumChannels; c++) begin
                cnt_q[c] <= '0;
                ps_q[c]  <= '0;
                ds_q[c]  <= '0;
                dir_q[c] <= DIR_UP;
            end
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                act_q[c]         <= active[c];
                center_seen_q[c] <= center_q[c];
                pwm_en_q[c]      <= active[c];
                pwm_q[c]         <= act_q[c] & active[c] & (raw[c] ^ inv_q[c]);

                if (!active[c]) begin
                    cnt_q[c] <= '0;
                    dir_q[c] <= DIR_UP;
                end else if (restart[c] || boundary[c]) begin
                    cnt_q[c] <= '0;
                    dir_q[c] <= DIR_UP;
                    ps_q[c]  <= period_q[c];
                    ds_q[c]  <= duty_q[c];
                end else if (tick) begin
                    if (!center_q[c]) begin
                        cnt_q[c] <= cnt_q[c] + CntOne;
                    end else if (dir_q[c] == DIR_UP) begin
                        cnt_q[c] <= cnt_q[c] + CntOne;
                        if (cnt_q[c] == ps_q[c] - CntOne) dir_q[c] <= DIR_DOWN;
                    end else begin
                        cnt_q[c] <= cnt_q[c] - CntOne;
                    end
                end
            end
        end
    end

    assign rvalid_o      = rvalid_q;
    assign err_o         = err_q;
    assign rdata_o       = rdata_q;
    assign cio_pwm_o     = pwm_q;
    assign cio_pwm_en_o  = pwm_en_q;
    assign intr_period_o = |status_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: self-checking bench for pwm_multi.
// A cycle-level model tracks each channel as a position within its period.
// A compare process checks every output against that model on every clock.
// Directed waveform measurements pin the model to hand-computed values.
module tb_pwm_multi;

    localparam int NC = 4;
    localparam int CW = 16;

    logic          clk_i   = 1'b0;
    logic          rst_ni  = 1'b0;
    logic          req_i   = 1'b0;
    logic          we_i    = 1'b0;
    logic [7:0]    addr_i  = '0;
    logic [31:0]   wdata_i = '0;
    logic [3:0]    be_i    = '0;
    logic          gnt_o;
    logic          rvalid_o;
    logic [31:0]   rdata_o;
    logic          err_o;
    logic [NC-1:0] cio_pwm_o;
    logic [NC-1:0] cio_pwm_en_o;
    logic          intr_period_o;

    pwm_multi #(.NumChannels(NC), .CntWidth(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .cio_pwm_o(cio_pwm_o), .cio_pwm_en_o(cio_pwm_en_o),
        .intr_period_o(intr_period_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic          m_gen;
    logic [7:0]    m_presc;
    int unsigned   m_pcnt;
    logic [NC-1:0] m_status, m_en, m_inv, m_center, m_act, m_cseen, m_pwm, m_pwm_en;
    int unsigned   m_period [NC];
    int unsigned   m_duty   [NC];
    int unsigned   m_ps     [NC];
    int unsigned   m_ds     [NC];
    longint        m_pos    [NC];
    logic          m_rvalid, m_err;
    logic [31:0]   m_rdata;

    task automatic modelReset();
        m_gen = 0; m_presc = 0; m_pcnt = 0;
        m_status = 0; m_en = 0; m_inv = 0; m_center = 0;
        m_act = 0; m_cseen = 0; m_pwm = 0; m_pwm_en = 0;
        m_rvalid = 0; m_err = 0; m_rdata = 0;
        for (int c = 0; c < NC; c++) begin
            m_period[c] = 0; m_duty[c] = 0; m_ps[c] = 0; m_ds[c] = 0; m_pos[c] = 0;
        end
    endtask

    // Counter value at a position: center mode folds the second half back down.
    function automatic longint modelCnt(input int c);
        longint ps = longint'(m_ps[c]);
        if (m_center[c] && m_pos[c] > ps) return 2 * ps - m_pos[c];
        return m_pos[c];
    endfunction

    function automatic longint periodLen(input int c);
        longint ps = longint'(m_ps[c]);
        if (ps == 0) return 1;
        return m_center[c] ? 2 * ps : ps + 1;
    endfunction

    // Returns 0 CTRL, 1 STATUS, 2 CFG, 3 PERIOD, 4 DUTY, -1 error.
    function automatic int decodeReg(input logic [7:0] a, output int ch);
        int base = int'(a) / 16;
        int off  = (int'(a) % 16) / 4;
        ch = 0;
        if (base == 0) return (off < 2) ? off : -1;
        ch = base - 1;
        if (ch >= NC || off == 3) return -1;
        return 2 + off;
    endfunction

    function automatic logic [31:0] modelRead(input int code, input int ch);
        case (code)
            0:       return {16'h0, m_presc, 7'h0, m_gen};
            1:       return 32'(m_status);
            2:       return {29'h0, m_center[ch], m_inv[ch], m_en[ch]};
            3:       return m_period[ch];
            4:       return m_duty[ch];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] applyBytes(input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic modelStep();
        logic          tick, active, rawv;
        logic [NC-1:0] bnd = '0;
        logic [NC-1:0] clr = '0;
        logic [31:0]   cur, merged;
        int            code, ch;
        tick = m_gen && (m_pcnt >= int'(m_presc));
        for (int c = 0; c < NC; c++) begin
            active = m_gen && m_en[c];
            rawv   = (modelCnt(c) < longint'(m_ds[c]));
            if (!active) begin
                m_pos[c] = 0;
                m_pwm[c] = 0;
            end else if (!m_act[c] || (m_center[c] != m_cseen[c])) begin
                m_pwm[c] = m_act[c] ? (rawv ^ m_inv[c]) : 1'b0;
                m_pos[c] = 0; m_ps[c] = m_period[c]; m_ds[c] = m_duty[c];
            end else begin
                m_pwm[c] = rawv ^ m_inv[c];
                if (tick) begin
                    if (m_pos[c] == periodLen(c) - 1) begin
                        bnd[c] = 1'b1;
                        m_pos[c] = 0; m_ps[c] = m_period[c]; m_ds[c] = m_duty[c];
                    end else begin
                        m_pos[c]++;
                    end
                end
            end
            m_act[c] = active; m_cseen[c] = m_center[c]; m_pwm_en[c] = active;
        end
        if (!m_gen || tick) m_pcnt = 0; else m_pcnt++;

        m_rvalid = req_i; m_err = 0; m_rdata = 0;
        if (req_i) begin
            code = decodeReg(addr_i, ch);
            if (code < 0) m_err = 1;
            else begin
                cur = modelRead(code, ch);
                if (!we_i) m_rdata = cur;
                else begin
                    merged = applyBytes(cur, wdata_i, be_i);
                    case (code)
                        0: begin m_gen = merged[0]; m_presc = merged[15:8]; end
                        1: if (be_i[0]) clr = wdata_i[NC-1:0];
                        2: begin m_en[ch] = merged[0]; m_inv[ch] = merged[1]; m_center[ch] = merged[2]; end
                        3: m_period[ch] = 32'(merged[CW-1:0]);
                        4: m_duty[ch]   = 32'(merged[CW-1:0]);
                        default: ;
                    endcase
                end
            end
        end
        m_status = (m_status & ~clr) | bnd;
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) modelReset();
        else         modelStep();
    end

    // Per-cycle compare against the model
    always @(posedge clk_i) begin
        #2;
        if (rst_ni) begin
            checkOutput("pwm", 32'(cio_pwm_o), 32'(m_pwm));
            checkOutput("pwm_en", 32'(cio_pwm_en_o), 32'(m_pwm_en));
            checkOutput("intr", 32'(intr_period_o), 32'(|m_status));
            checkOutput("gnt", 32'(gnt_o), 32'(req_i));
            checkOutput("rvalid", 32'(rvalid_o), 32'(m_rvalid));
            if (m_rvalid) begin
                checkOutput("err", 32'(err_o), 32'(m_err));
                checkOutput("rdata", rdata_o, m_rdata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the following negedge.
    task automatic applyStimulus(input logic we, input logic [7:0] a, input logic [31:0] d,
                                 input logic [3:0] b, output logic [31:0] rd, output logic er);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d; be_i = b;
        @(posedge clk_i); #2;
        rd = rdata_o; er = err_o;
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic writeReg(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] rd; logic er;
        applyStimulus(1'b1, a, d, 4'hF, rd, er);
    endtask

    task automatic countHigh(input int ch, input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk_i); #2;
            if (cio_pwm_o[ch]) cnt++;
        end
        @(negedge clk_i);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          hc;
        logic [7:0]  a;
        logic [31:0] d;
        int          ch, off;

        modelReset();
        repeat (3) @(negedge clk_i);
        checkOutput("reset_pwm", 32'(cio_pwm_o), 32'h0);
        checkOutput("reset_pwm_en", 32'(cio_pwm_en_o), 32'h0);
        checkOutput("reset_intr", 32'(intr_period_o), 32'h0);
        checkOutput("reset_rvalid", 32'(rvalid_o), 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        applyStimulus(1'b0, 8'h00, 0, 4'hF, rd, er); checkOutput("reset_ctrl", rd, 32'h0);
        applyStimulus(1'b0, 8'h04, 0, 4'hF, rd, er); checkOutput("reset_status", rd, 32'h0);
        for (int c = 0; c < NC; c++) begin
            for (int o = 0; o < 3; o++) begin
                applyStimulus(1'b0, 8'(16 + 16 * c + 4 * o), 0, 4'hF, rd, er);
                checkOutput("reset_chreg", rd, 32'h0);
            end
        end

        // Edge mode: 3 high / 7 low every 10 clocks
        writeReg(8'h14, 9); writeReg(8'h18, 3); writeReg(8'h10, 1); writeReg(8'h00, 1);
        repeat (5) @(negedge clk_i);
        countHigh(0, 10, hc); checkOutput("edge_high10", 32'(hc), 32'd3);
        countHigh(0, 20, hc); checkOutput("edge_high20", 32'(hc), 32'd6);
        writeReg(8'h04, 32'hF);
        repeat (12) @(negedge clk_i);
        applyStimulus(1'b0, 8'h04, 0, 4'hF, rd, er);
        checkOutput("edge_status0", rd & 32'h1, 32'h1);
        checkOutput("edge_intr", 32'(intr_period_o), 32'h1);

        // Mid-period duty change takes effect at the next period
        writeReg(8'h18, 7);
        repeat (12) @(negedge clk_i);
        countHigh(0, 10, hc); checkOutput("edge_duty7", 32'(hc), 32'd7);
        applyStimulus(1'b0, 8'h18, 0, 4'hF, rd, er); checkOutput("duty_readback", rd, 32'd7);

        // Center mode, PRESCALE=1: 16-clock period, counts 0,1,2,3,4,3,2,1 -> 3 of 8 ticks high
        writeReg(8'h00, 0); writeReg(8'h14, 4); writeReg(8'h18, 2); writeReg(8'h10, 5);
        writeReg(8'h00, 32'h101);
        repeat (20) @(negedge clk_i);
        countHigh(0, 16, hc); checkOutput("center_high16", 32'(hc), 32'd6);
        writeReg(8'h10, 7);
        repeat (4) @(negedge clk_i);
        countHigh(0, 16, hc); checkOutput("center_inv16", 32'(hc), 32'd10);

        // Duty limits
        writeReg(8'h00, 1); writeReg(8'h10, 1); writeReg(8'h14, 9); writeReg(8'h18, 0);
        repeat (25) @(negedge clk_i);
        countHigh(0, 10, hc); checkOutput("duty0_low", 32'(hc), 32'd0);
        writeReg(8'h18, 10);
        repeat (15) @(negedge clk_i);
        countHigh(0, 10, hc); checkOutput("duty_over_high", 32'(hc), 32'd10);
        writeReg(8'h14, 0); writeReg(8'h18, 1);
        repeat (15) @(negedge clk_i);
        countHigh(0, 10, hc); checkOutput("period0_high", 32'(hc), 32'd10);
        writeReg(8'h04, 1);
        applyStimulus(1'b0, 8'h04, 0, 4'hF, rd, er);
        checkOutput("period0_status", rd & 32'h1, 32'h1);
        checkOutput("period0_en", 32'(cio_pwm_en_o[0]), 32'h1);

        // Bus errors and W1C of zero
        writeReg(8'h00, 0);
        applyStimulus(1'b0, 8'h0C, 0, 4'hF, rd, er);
        checkOutput("err_0c", 32'(er), 32'h1); checkOutput("err_0c_rdata", rd, 32'h0);
        applyStimulus(1'b0, 8'(16 + 16 * NC), 0, 4'hF, rd, er);
        checkOutput("err_chan_range", 32'(er), 32'h1);
        applyStimulus(1'b1, 8'h04, 0, 4'hF, rd, er);
        checkOutput("w1c_zero_err", 32'(er), 32'h0);
        applyStimulus(1'b0, 8'h04, 0, 4'hF, rd, er);
        checkOutput("w1c_zero_keep", rd, 32'h1);
        writeReg(8'h04, 1);
        applyStimulus(1'b0, 8'h04, 0, 4'hF, rd, er);
        checkOutput("w1c_clear", rd, 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            ch  = int'($urandom_range(0, NC + 1)) - 1;
            off = int'($urandom_range(0, 3));
            if (ch < 0) a = 8'(4 * off);
            else        a = 8'(16 + 16 * ch + 4 * off);
            a[1:0] = 2'($urandom_range(0, 3));
            if (ch < 0 && off == 0)      d = {16'h0, 8'($urandom_range(0, 3)), 7'h0, 1'($urandom_range(0, 6) != 0)};
            else if (ch < 0)             d = $urandom;
            else if (off == 0)           d = $urandom_range(0, 7);
            else if (off == 1)           d = $urandom_range(0, 12);
            else                         d = $urandom_range(0, 14);
            applyStimulus(1'($urandom_range(0, 9) < 6), a, d,
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, rd, er);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end

        // Asynchronous reset mid-waveform with the output held high
        writeReg(8'h14, 5); writeReg(8'h18, 9); writeReg(8'h10, 1); writeReg(8'h00, 1);
        repeat (10) @(negedge clk_i);
        checkOutput("pre_reset_pwm", 32'(cio_pwm_o[0]), 32'h1);
        @(posedge clk_i); #3;
        rst_ni = 1'b0;
        #1;
        checkOutput("async_pwm", 32'(cio_pwm_o), 32'h0);
        checkOutput("async_pwm_en", 32'(cio_pwm_en_o), 32'h0);
        checkOutput("async_intr", 32'(intr_period_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        applyStimulus(1'b0, 8'h14, 0, 4'hF, rd, er);
        checkOutput("post_reset_period", rd, 32'h0);
        repeat (3) @(negedge clk_i);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
